ir_fetch_ctrl: RTL



---
 rtl/ir_ctrl_pkg.sv | 30 +++
 rtl/ir_fetch_ctrl_if.sv | 39 +++
 rtl/ir_fetch_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ir_ctrl_pkg.sv
// Shared types and constants for the instruction-register fetch controller.
package ir_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_REQ_LO = 3'd2,
        ST_REQ_HI = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } ir_state_e;

    // IR function-select encodings; DEC/INC exist on the IR but are never issued here
    localparam logic [1:0] FS_CLR  = 2'b00;
    localparam logic [1:0] FS_LOAD = 2'b01;
    localparam logic [1:0] FS_DEC  = 2'b10;
    localparam logic [1:0] FS_INC  = 2'b11;

    localparam logic LH_LO = 1'b0;
    localparam logic LH_HI = 1'b1;

    function automatic logic is_req_state(input ir_state_e s);
        return (s == ST_REQ_LO) || (s == ST_REQ_HI);
    endfunction

    function automatic logic accepts_cmd(input ir_state_e s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
    endfunction

endpackage

// File: rtl/ir_fetch_ctrl_if.sv
// Control, memory-handshake and IR-drive signals of the fetch controller.
interface ir_fetch_ctrl_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              start;
    logic              flush;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_in;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [7:0]        mem_rdata;

    logic [7:0]        ir_i;
    logic [1:0]        ir_funsel;
    logic              ir_lh;
    logic              ir_en;

    logic              ir_valid;
    logic              busy;
    logic              err;
    logic [ADDR_W-1:0] pc;

    // Controller side
    modport master (
        input  start, flush, pc_load, pc_in, mem_ready, mem_rdata,
        output mem_req, mem_addr, ir_i, ir_funsel, ir_lh, ir_en,
               ir_valid, busy, err, pc
    );

    // Environment side: control unit, memory and IR
    modport slave (
        output start, flush, pc_load, pc_in, mem_ready, mem_rdata,
        input  mem_req, mem_addr, ir_i, ir_funsel, ir_lh, ir_en,
               ir_valid, busy, err, pc
    );

endinterface

// File: rtl/ir_fetch_ctrl.sv
// Fills the 16-bit IR from byte memory: clear, load low byte, load high byte.
// Optional per-byte wait timeout enabled with `define IR_TIMEOUT_EN.
module ir_fetch_ctrl
    import ir_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W         = 8,
    parameter logic [ADDR_W-1:0] PC_RESET       = '0,
    parameter int unsigned       TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    ir_fetch_ctrl_if.master    bus
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    ir_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    logic              mem_req;
    logic [7:0]        ir_i;
    logic [1:0]        ir_funsel;
    logic              ir_lh;
    logic              ir_en;
    logic              ir_valid;
    logic              busy;
    logic              err;

`ifdef IR_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        mem_req   = 1'b0;
        ir_i      = '0;
        ir_funsel = FS_CLR;
        ir_lh     = LH_LO;
        ir_en     = 1'b0;
        ir_valid  = 1'b0;
        busy      = 1'b0;
        err       = 1'b0;
`ifdef IR_TIMEOUT_EN
        wait_d    = wait_q;
`endif

        if (accepts_cmd(state_q) && bus.pc_load) begin
            pc_d = bus.pc_in;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_CLR;
            end

            ST_CLR: begin
                busy      = 1'b1;
                ir_en     = 1'b1;
                ir_funsel = FS_CLR;
                state_d   = ST_REQ_LO;
`ifdef IR_TIMEOUT_EN
                wait_d    = '0;
`endif
            end

            ST_REQ_LO, ST_REQ_HI: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                ir_lh   = (state_q == ST_REQ_HI) ? LH_HI : LH_LO;
                if (bus.mem_ready) begin
                    ir_en     = 1'b1;
                    ir_funsel = FS_LOAD;
                    ir_i      = bus.mem_rdata;
                    pc_d      = pc_q + 1'b1;
                    state_d   = (state_q == ST_REQ_HI) ? ST_DONE : ST_REQ_HI;
`ifdef IR_TIMEOUT_EN
                    wait_d    = '0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = ST_ERR;
                end else begin
                    wait_d    = wait_q + 1'b1;
`endif
                end
            end

            ST_DONE: begin
                ir_valid = 1'b1;
                if (bus.start) state_d = ST_CLR;
            end

            ST_ERR: begin
`ifdef IR_TIMEOUT_EN
                err = 1'b1;
`endif
                if (bus.start) state_d = ST_CLR;
            end

            default: state_d = ST_IDLE;
        endcase

        // Flush overrides everything: no IR write and no pc change this cycle,
        // while mem_req/busy follow the current state and drop next cycle.
        if (bus.flush) begin
            state_d   = ST_IDLE;
            pc_d      = pc_q;
            ir_en     = 1'b0;
            ir_funsel = FS_CLR;
            ir_lh     = LH_LO;
            ir_i      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= PC_RESET;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef IR_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`endif

    assign bus.mem_req   = mem_req;
    assign bus.mem_addr  = pc_q;
    assign bus.ir_i      = ir_i;
    assign bus.ir_funsel = ir_funsel;
    assign bus.ir_lh     = ir_lh;
    assign bus.ir_en     = ir_en;
    assign bus.ir_valid  = ir_valid;
    assign bus.busy      = busy;
    assign bus.err       = err;
    assign bus.pc        = pc_q;

endmodule
